// File: rtl/color_frame_classifier.sv
// Frame-level RGB565 colour classifier: counts red/green/blue pixels over a frame and
// issues a registered majority decision on led with a one-cycle result_valid strobe.
module color_frame_classifier #(
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned R_HI       = 17,
    parameter int unsigned R_LO       = 11,
    parameter int unsigned G_HI       = 28,
    parameter int unsigned G_LO       = 20,
    parameter int unsigned B_HI       = 17,
    parameter int unsigned B_LO       = 11
) (
    input  logic             p_clock,
    input  logic             rst_n,
    input  logic             pixel_valid,
    input  logic [15:0]      pixel_data,
    input  logic             frame_start,
    input  logic             frame_end,
    output logic [2:0]       led,
    output logic             result_valid,
    output logic [CNT_W-1:0] count_r,
    output logic [CNT_W-1:0] count_g,
    output logic [CNT_W-1:0] count_b,
    output logic             busy
);

    localparam logic [4:0]       RHiV = 5'(R_HI);
    localparam logic [4:0]       RLoV = 5'(R_LO);
    localparam logic [5:0]       GHiV = 6'(G_HI);
    localparam logic [5:0]       GLoV = 6'(G_LO);
    localparam logic [4:0]       BHiV = 5'(B_HI);
    localparam logic [4:0]       BLoV = 5'(B_LO);
    localparam logic [CNT_W-1:0] MinV = CNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDecide} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cls_q, cls_d;  // one-hot {red, green, blue}; 000 = none
    logic [CNT_W-1:0] cnt_r_q, cnt_r_d, cnt_g_q, cnt_g_d, cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0] out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
    logic [2:0]       led_q, led_d;
    logic             valid_q, valid_d;

    logic [4:0] pix_r;
    logic [5:0] pix_g;
    logic [4:0] pix_b;
    logic [2:0] pix_cls;

    assign pix_r = pixel_data[15:11];
    assign pix_g = pixel_data[10:5];
    assign pix_b = pixel_data[4:0];

    assign pix_cls[2] = (pix_r > RHiV) && (pix_g < GLoV) && (pix_b < BLoV);
    assign pix_cls[1] = (pix_r < RLoV) && (pix_g > GHiV) && (pix_b < BLoV);
    assign pix_cls[0] = (pix_r < RLoV) && (pix_g < GLoV) && (pix_b > BHiV);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Majority decision over the settled counters
    logic             max_r, max_g, max_b;
    logic [CNT_W-1:0] max_val;
    logic [2:0]       decision;

    always_comb begin
        max_r    = (cnt_r_q >= cnt_g_q) && (cnt_r_q >= cnt_b_q);
        max_g    = (cnt_g_q >= cnt_r_q) && (cnt_g_q >= cnt_b_q);
        max_b    = (cnt_b_q >= cnt_r_q) && (cnt_b_q >= cnt_g_q);
        max_val  = max_r ? cnt_r_q : (max_g ? cnt_g_q : cnt_b_q);
        decision = 3'b000;
        if (max_val < MinV) begin
            decision = 3'b000;
        end else if ($onehot({max_r, max_g, max_b})) begin
            decision = {max_r, max_g, max_b};
        end else begin
            decision = 3'b111;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = 3'b000;
        cnt_r_d = sat_inc(cnt_r_q, cls_q[2]);
        cnt_g_d = sat_inc(cnt_g_q, cls_q[1]);
        cnt_b_d = sat_inc(cnt_b_q, cls_q[0]);
        out_r_d = out_r_q;
        out_g_d = out_g_q;
        out_b_d = out_b_q;
        led_d   = led_q;
        valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (frame_start) begin
                    cnt_r_d = '0;
                    cnt_g_d = '0;
                    cnt_b_d = '0;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                // A restart wins over a simultaneous frame_end and drops the partial frame
                if (frame_start) begin
                    cnt_r_d = '0;
                    cnt_g_d = '0;
                    cnt_b_d = '0;
                end else begin
                    if (pixel_valid) begin
                        cls_d = pix_cls;
                    end
                    if (frame_end) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                state_d = StDecide;
            end
            StDecide: begin
                led_d   = decision;
                out_r_d = cnt_r_q;
                out_g_d = cnt_g_q;
                out_b_d = cnt_b_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cls_q   <= 3'b000;
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
            out_r_q <= '0;
            out_g_q <= '0;
            out_b_q <= '0;
            led_q   <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_r_q <= cnt_r_d;
            cnt_g_q <= cnt_g_d;
            cnt_b_q <= cnt_b_d;
            out_r_q <= out_r_d;
            out_g_q <= out_g_d;
            out_b_q <= out_b_d;
            led_q   <= led_d;
            valid_q <= valid_d;
        end
    end

    assign led          = led_q;
    assign result_valid = valid_q;
    assign count_r      = out_r_q;
    assign count_g      = out_g_q;
    assign count_b      = out_b_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_color_frame_classifier.sv
// Directed bench for color_frame_classifier: default instance plus a narrow-counter
// instance (CNT_W=4, MIN_PIXELS=4) sharing the same stimulus.
module tb_color_frame_classifier;

    logic        p_clock = 1'b0;
    logic        rst_n;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic        frame_start;
    logic        frame_end;

    logic [2:0]  led;
    logic        result_valid;
    logic [19:0] count_r, count_g, count_b;
    logic        busy;

    logic [2:0]  led2;
    logic        result_valid2;
    logic [3:0]  count_r2, count_g2, count_b2;
    logic        busy2;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    localparam logic [15:0] Red   = 16'hF800;
    localparam logic [15:0] Green = 16'h07E0;
    localparam logic [15:0] Blue  = 16'h001F;
    localparam logic [15:0] Gray  = 16'h8410;

    color_frame_classifier dut (
        .p_clock      (p_clock),
        .rst_n        (rst_n),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .led          (led),
        .result_valid (result_valid),
        .count_r      (count_r),
        .count_g      (count_g),
        .count_b      (count_b),
        .busy         (busy)
    );

    color_frame_classifier #(
        .CNT_W      (4),
        .MIN_PIXELS (4)
    ) dut_narrow (
        .p_clock      (p_clock),
        .rst_n        (rst_n),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .led          (led2),
        .result_valid (result_valid2),
        .count_r      (count_r2),
        .count_g      (count_g2),
        .count_b      (count_b2),
        .busy         (busy2)
    );

    always #5 p_clock = ~p_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_clock);
        #1;
    endtask

    task automatic pix(input logic valid, input logic [15:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = valid;
            pixel_data  = data;
            tick();
        end
        pixel_valid = 1'b0;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Leaves the bench just after edge e+2 (the result edge)
    task automatic end_frame(input logic valid, input logic [15:0] data);
        pixel_valid = valid;
        pixel_data  = data;
        frame_end   = 1'b1;
        tick();
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        check("busy_flush", 32'(busy), 1);
        tick();
        check("rv_e1", 32'(result_valid), 0);
        tick();
    endtask

    task automatic expect_result(input string tag, input logic [2:0] e_led,
                                 input int e_r, input int e_g, input int e_b);
        check({tag, "_rv"}, 32'(result_valid), 1);
        check({tag, "_led"}, 32'(led), 32'(e_led));
        check({tag, "_r"}, 32'(count_r), e_r);
        check({tag, "_g"}, 32'(count_g), e_g);
        check({tag, "_b"}, 32'(count_b), e_b);
        tick();
        check({tag, "_rv_e3"}, 32'(result_valid), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = 16'h0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        #12;
        check("rst_led", 32'(led), 0);
        check("rst_r", 32'(count_r), 0);
        check("rst_rv", 32'(result_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Majority red; last red pixel rides on the frame_end cycle
        start_frame();
        check("busy_accum", 32'(busy), 1);
        pix(1'b1, Green, 20);
        pix(1'b1, Blue, 5);
        pix(1'b1, Red, 99);
        end_frame(1'b1, Red);
        expect_result("major", 3'b100, 100, 20, 5);
        tick();
        tick();
        check("led_hold", 32'(led), 32'(3'b100));
        check("cnt_hold", 32'(count_r), 100);

        // Asynchronous reset mid-frame
        start_frame();
        pix(1'b1, Red, 30);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", 32'(led), 0);
        check("arst_r", 32'(count_r), 0);
        check("arst_g", 32'(count_g), 0);
        check("arst_busy", 32'(busy), 0);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arst_no_rv", 32'(result_valid), 0);
        end
        check("arst_busy_after", 32'(busy), 0);

        // Two-way tie between green and blue
        start_frame();
        pix(1'b1, Green, 50);
        pix(1'b1, Blue, 50);
        end_frame(1'b0, 16'h0);
        expect_result("tie", 3'b111, 0, 50, 50);

        // Winner below MIN_PIXELS; gray pixels are class none
        start_frame();
        pix(1'b1, Red, 10);
        pix(1'b1, Gray, 200);
        end_frame(1'b0, 16'h0);
        expect_result("below", 3'b000, 10, 0, 0);

        // Saturation on the narrow instance
        start_frame();
        pix(1'b1, Blue, 20);
        end_frame(1'b0, 16'h0);
        check("sat_rv2", 32'(result_valid2), 1);
        check("sat_b2", 32'(count_b2), 15);
        check("sat_led2", 32'(led2), 32'(3'b001));
        check("sat_r2", 32'(count_r2), 0);
        expect_result("sat_wide", 3'b001, 0, 0, 20);

        // Restart mid-frame (with a simultaneous frame_end) and invalid gaps
        start_frame();
        pix(1'b1, Red, 30);
        frame_start = 1'b1;
        frame_end   = 1'b1;
        pixel_valid = 1'b1;
        pixel_data  = Red;
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pixel_valid = 1'b0;
        check("restart_busy", 32'(busy), 1);
        for (int i = 0; i < 40; i++) begin
            pix(1'b1, Green, 1);
            pix(1'b0, Red, 1);
        end
        check("restart_no_rv", 32'(result_valid), 0);
        end_frame(1'b0, 16'h0);
        expect_result("restart", 3'b010, 0, 40, 0);

        // frame_end while idle is ignored
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_end_rv", 32'(result_valid), 0);
        end
        check("idle_end_busy", 32'(busy), 0);
        check("idle_end_led", 32'(led), 32'(3'b010));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
